// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop RxD synchronizer, mid-bit sampling FSM, single-byte holding register.
// dataReady rises 2 + HALF_CYCLES + 9*BIT_CYCLES edges after the first edge that samples RxD low.
module uart_receiver #(
    parameter int BIT_CYCLES  = 49,
    parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       readAck,
    output logic [7:0] RxData,
    output logic       dataReady,
    output logic       frameError,
    output logic       overrun,
    output logic       isBusy
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rxState_t;

    rxState_t         state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0]       bitIdx, bitIdxNext;
    logic [7:0]       shiftReg, shiftNext;
    logic [7:0]       dataNext;
    logic             readyNext, frameErrNext, overrunNext;
    logic             rxMeta, rxs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta     <= 1'b1;
            rxs        <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            RxData     <= '0;
            dataReady  <= 1'b0;
            frameError <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rxMeta     <= RxD;
            rxs        <= rxMeta;
            state      <= stateNext;
            cnt        <= cntNext;
            bitIdx     <= bitIdxNext;
            shiftReg   <= shiftNext;
            RxData     <= dataNext;
            dataReady  <= readyNext;
            frameError <= frameErrNext;
            overrun    <= overrunNext;
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        bitIdxNext   = bitIdx;
        shiftNext    = shiftReg;
        dataNext     = RxData;
        readyNext    = dataReady;
        frameErrNext = 1'b0;
        overrunNext  = 1'b0;

        if (readAck && dataReady) begin
            readyNext = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!rxs) begin
                    stateNext = START;
                    cntNext   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cntNext    = '0;
                    bitIdxNext = '0;
                    stateNext  = rxs ? IDLE : DATA;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shiftNext  = {rxs, shiftReg[7:1]};
                    cntNext    = '0;
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cntNext = '0;
                    if (rxs) begin
                        // A coincident ack consumes the old byte, so the new one is not an overrun.
                        dataNext    = shiftReg;
                        readyNext   = 1'b1;
                        overrunNext = dataReady && !readAck;
                        stateNext   = IDLE;
                    end else begin
                        frameErrNext = 1'b1;
                        stateNext    = WAIT_HIGH;
                    end
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign isBusy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good frames, overrun, framing error, glitch, reset mid-frame, ack at stop.
module tb_uart_receiver;

    localparam int BIT_CYCLES  = 49;
    localparam int HALF_CYCLES = 24;
    // Edges from the first RxD-low sampling edge to the edge that raises dataReady.
    localparam int LATENCY     = 2 + HALF_CYCLES + 9 * BIT_CYCLES;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic       readAck;
    logic [7:0] RxData;
    logic       dataReady;
    logic       frameError;
    logic       overrun;
    logic       isBusy;

    uart_receiver #(
        .BIT_CYCLES (BIT_CYCLES),
        .HALF_CYCLES(HALF_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RxD       (RxD),
        .readAck   (readAck),
        .RxData    (RxData),
        .dataReady (dataReady),
        .frameError(frameError),
        .overrun   (overrun),
        .isBusy    (isBusy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned readyRiseCnt = 0;
    int unsigned readyRiseCyc = 0;
    int unsigned busyFallCyc  = 0;
    int unsigned frameErrCnt  = 0;
    int unsigned overrunCnt   = 0;
    logic        prevReady    = 1'b0;
    logic        prevBusy     = 1'b0;

    always @(negedge clk) begin
        if (dataReady && !prevReady) begin
            readyRiseCnt = readyRiseCnt + 1;
            readyRiseCyc = cyc;
        end
        if (!isBusy && prevBusy) busyFallCyc = cyc;
        if (frameError) frameErrCnt = frameErrCnt + 1;
        if (overrun) overrunCnt = overrunCnt + 1;
        prevReady = dataReady;
        prevBusy  = isBusy;
    end

    int          total = 0;
    int          bad   = 0;
    int unsigned startCyc = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, then the stop bit; RxD is left at stopBit.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input bit ackAtStop);
        logic [9:0] frame;
        frame = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RxD = frame[i];
            if (i == 0) startCyc = cyc;
            for (int c = 0; c < BIT_CYCLES; c++) begin
                @(posedge clk);
                #1;
                if (ackAtStop) readAck = (cyc == startCyc + LATENCY);
            end
        end
    endtask

    int unsigned base0, base1, base2;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        RxD     = 1'b1;
        readAck = 1'b0;
        waitCycles(3);
        checkVal("rstData", 32'(RxData), 32'h00);
        checkVal("rstReady", 32'(dataReady), 32'd0);
        checkVal("rstBusy", 32'(isBusy), 32'd0);
        checkVal("rstFerr", 32'(frameError), 32'd0);
        reset = 1'b1;
        waitCycles(5);

        // Scenario 1: 0xA5, latency and busy/ready alignment
        sendFrame(8'hA5, 1'b1, 1'b0);
        waitCycles(5);
        checkVal("s1Data", 32'(RxData), 32'hA5);
        checkVal("s1Ready", 32'(dataReady), 32'd1);
        checkVal("s1Rises", readyRiseCnt, 32'd1);
        checkVal("s1Latency", readyRiseCyc - startCyc, 32'(LATENCY + 1));
        checkVal("s1BusyFall", busyFallCyc, readyRiseCyc);
        checkVal("s1Ferr", frameErrCnt, 32'd0);
        readAck = 1'b1;
        waitCycles(1);
        readAck = 1'b0;
        checkVal("s1AckClr", 32'(dataReady), 32'd0);

        // Scenario 2: back-to-back frames, overrun
        base0 = overrunCnt;
        sendFrame(8'h3C, 1'b1, 1'b0);
        checkVal("s2First", 32'(RxData), 32'h3C);
        sendFrame(8'hC3, 1'b1, 1'b0);
        waitCycles(2);
        checkVal("s2Data", 32'(RxData), 32'hC3);
        checkVal("s2Ready", 32'(dataReady), 32'd1);
        checkVal("s2Overrun", overrunCnt - base0, 32'd1);
        readAck = 1'b1;
        waitCycles(1);
        readAck = 1'b0;
        checkVal("s2AckClr", 32'(dataReady), 32'd0);

        // Scenario 3: bad stop bit followed by a break
        base0 = frameErrCnt;
        base1 = readyRiseCnt;
        sendFrame(8'h55, 1'b0, 1'b0);
        waitCycles(200);
        checkVal("s3Ferr", frameErrCnt - base0, 32'd1);
        checkVal("s3Data", 32'(RxData), 32'hC3);
        checkVal("s3Ready", 32'(dataReady), 32'd0);
        checkVal("s3BusyLow", 32'(isBusy), 32'd1);
        RxD = 1'b1;
        waitCycles(5);
        checkVal("s3Idle", 32'(isBusy), 32'd0);
        waitCycles(20);
        checkVal("s3NoRise", readyRiseCnt - base1, 32'd0);

        // Scenario 4: 10-clock glitch
        base0 = frameErrCnt;
        base1 = readyRiseCnt;
        base2 = overrunCnt;
        RxD = 1'b0;
        waitCycles(10);
        checkVal("s4Started", 32'(isBusy), 32'd1);
        RxD = 1'b1;
        waitCycles(60);
        checkVal("s4Idle", 32'(isBusy), 32'd0);
        checkVal("s4NoRise", readyRiseCnt - base1, 32'd0);
        checkVal("s4NoFerr", frameErrCnt - base0, 32'd0);
        checkVal("s4NoOvr", overrunCnt - base2, 32'd0);

        // Scenario 6: ack coincident with a good stop sample
        sendFrame(8'h5A, 1'b1, 1'b0);
        checkVal("s6Pre", 32'(dataReady), 32'd1);
        base2 = overrunCnt;
        sendFrame(8'h96, 1'b1, 1'b1);
        readAck = 1'b0;
        waitCycles(2);
        checkVal("s6Data", 32'(RxData), 32'h96);
        checkVal("s6Ready", 32'(dataReady), 32'd1);
        checkVal("s6NoOvr", overrunCnt - base2, 32'd0);

        // Scenario 5: reset during bit 4 of 0xF0 (remaining bits are all high)
        RxD = 1'b0;
        waitCycles(5 * BIT_CYCLES);
        RxD = 1'b1;
        waitCycles(20);
        reset = 1'b0;
        #1;
        checkVal("s5RstData", 32'(RxData), 32'h00);
        checkVal("s5RstReady", 32'(dataReady), 32'd0);
        checkVal("s5RstBusy", 32'(isBusy), 32'd0);
        checkVal("s5RstPulses", 32'({frameError, overrun}), 32'd0);
        waitCycles(5);
        reset = 1'b1;
        base1 = readyRiseCnt;
        waitCycles(4 * BIT_CYCLES);
        checkVal("s5NoPartial", readyRiseCnt - base1, 32'd0);
        checkVal("s5Idle", 32'(isBusy), 32'd0);
        base0 = frameErrCnt;
        sendFrame(8'h81, 1'b1, 1'b0);
        waitCycles(5);
        checkVal("s5Data", 32'(RxData), 32'h81);
        checkVal("s5Ready", 32'(dataReady), 32'd1);
        checkVal("s5Rise", readyRiseCnt - base1, 32'd1);
        checkVal("s5Latency", readyRiseCyc - startCyc, 32'(LATENCY + 1));
        checkVal("s5NoFerr", frameErrCnt - base0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
